// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer that latches comb-read instruction memory words into a
// valid/ready instruction register, applies taken branches, halts on HALT_WORD, counts retirements.
module fetch_sequencer #(
  parameter int              PC_W      = 4,
  parameter int              INS_W     = 9,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter logic [INS_W-1:0] HALT_WORD = '1,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [PC_W-1:0]  pc_o,
  input  logic [INS_W-1:0] ins_i,
  output logic [INS_W-1:0] ir_o,
  output logic             ir_valid_o,
  input  logic             ir_ready_i,
  input  logic             br_take_i,
  input  logic [PC_W-1:0]  br_target_i,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [1:0]       state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, ISSUE = 2'b10, HALT = 2'b11} state_t;
  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [INS_W-1:0] ir_q;
  logic             ir_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= START_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else if (stop_i) begin
      // stop wins over everything, including a handshake in the same cycle
      state_q    <= IDLE;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_q <= FETCH;
        FETCH:
          if (ins_i == HALT_WORD) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            ir_q       <= ins_i;
            ir_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        ISSUE:
          if (ir_ready_i) begin
            ir_valid_q <= 1'b0;
            if (retired_q != '1) retired_q <= retired_q + 1'b1;
            pc_q    <= br_take_i ? br_target_i : pc_q + 1'b1;
            state_q <= FETCH;
          end
        HALT:
          if (start_i) begin
            pc_q     <= START_PC;
            halted_q <= 1'b0;
            state_q  <= FETCH;
          end
      endcase
    end
  end
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign halted_o   = halted_q;
  assign retired_o  = retired_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random traffic against a behavioural model;
// a second instance with a 2-bit counter exercises saturation.
module tb_fetch_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, ir_ready = 1'b0, br_take = 1'b0;
  logic [3:0] br_target = '0;
  logic [8:0] mem [16];
  logic [3:0] pc, pc2;
  logic [8:0] ins, ins2, ir, ir2;
  logic ir_valid, ir_valid2, halted, halted2;
  logic [7:0] retired;
  logic [1:0] retired2, state, state2;
  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  assign ins  = mem[pc];
  assign ins2 = mem[pc2];
  fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .pc_o(pc),
    .ins_i(ins), .ir_o(ir), .ir_valid_o(ir_valid), .ir_ready_i(ir_ready), .br_take_i(br_take),
    .br_target_i(br_target), .halted_o(halted), .retired_o(retired), .state_o(state));
  fetch_sequencer #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
    .pc_o(pc2), .ins_i(ins2), .ir_o(ir2), .ir_valid_o(ir_valid2), .ir_ready_i(ir_ready),
    .br_take_i(br_take), .br_target_i(br_target), .halted_o(halted2), .retired_o(retired2),
    .state_o(state2));
  // model: mode 0 idle, 1 fetch, 2 waiting for acceptance, 3 halted; n counts every acceptance
  int m_mode = 0, m_pc = 0, m_ir = 0, m_n = 0;
  bit m_v = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_ir = 0; m_v = 1'b0; m_n = 0;
    end else if (stop) begin
      m_mode = 0; m_v = 1'b0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (mem[m_pc] == 9'h1FF) m_mode = 3;
      else begin m_ir = int'(mem[m_pc]); m_v = 1'b1; m_mode = 2; end
    end else if (m_mode == 2) begin
      if (ir_ready) begin
        m_v = 1'b0; m_n = m_n + 1;
        m_pc = br_take ? int'(br_target) : (m_pc + 1) % 16;
        m_mode = 1;
      end
    end else if (start) begin
      m_pc = 0; m_mode = 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("state", 32'(state), 32'(m_mode));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("ir_valid", 32'(ir_valid), 32'(m_v));
    chk("halted", 32'(halted), 32'(m_mode == 3));
    chk("retired", 32'(retired), 32'(m_n > 255 ? 255 : m_n));
    chk("retired2", 32'(retired2), 32'(m_n > 3 ? 3 : m_n));
    chk("state2", 32'(state2), 32'(m_mode));
    chk("pc2", 32'(pc2), 32'(m_pc));
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic wait_issue_at(input int p);
    int k = 0;
    while (!(ir_valid && pc == 4'(p)) && k < 100) begin step(); k++; end
    chk("wait_issue", 32'(ir_valid && pc == 4'(p)), 32'd1);
  endtask
  task automatic wait_halt();
    int k = 0;
    while (!halted && k < 100) begin step(); k++; end
    chk("wait_halt", 32'(halted), 32'd1);
  endtask
  initial begin
    logic [7:0] r;
    for (int i = 0; i < 16; i++) mem[i] = 9'($urandom_range(0, 9'h1FE));
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h1FF;
    step(); step();
    chk("rst_pc", 32'(pc), 0); chk("rst_ir", 32'(ir), 0); chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_state", 32'(state), 0); chk("rst_retired", 32'(retired), 0);
    rst_n = 1'b1; chk_on = 1'b1;
    ir_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    step(); chk("t1_ir0", 32'(ir), 32'h011); chk("t1_v0", 32'(ir_valid), 1);
    step(); step(); chk("t1_ir1", 32'(ir), 32'h022);
    step(); step();
    chk("t1_halted", 32'(halted), 1); chk("t1_pc", 32'(pc), 2); chk("t1_ret", 32'(retired), 2);
    mem[2] = 9'h033;
    ir_ready = 1'b0; start = 1'b1; step(); start = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_ir", 32'(ir), 32'h011); chk("t2_v", 32'(ir_valid), 1); chk("t2_pc", 32'(pc), 0);
    end
    ir_ready = 1'b1; step();
    chk("t2_pc1", 32'(pc), 1); chk("t2_ret", 32'(retired), 3);
    wait_issue_at(3);
    br_take = 1'b1; br_target = 4'hC; step(); br_take = 1'b0; br_target = 4'h3;
    chk("t3_br", 32'(pc), 32'hC);
    wait_issue_at(15); step();
    chk("t3_wrap", 32'(pc), 0);
    wait_issue_at(5);
    r = retired; stop = 1'b1; step(); stop = 1'b0;
    chk("t4_state", 32'(state), 0); chk("t4_v", 32'(ir_valid), 0);
    chk("t4_pc", 32'(pc), 5); chk("t4_ret", 32'(retired), 32'(r));
    ir_ready = 1'b0; start = 1'b1; step(); start = 1'b0; step();
    chk("t5_pre", 32'(ir_valid), 1);
    #2 rst_n = 1'b0; #1;
    chk("t5_state", 32'(state), 0); chk("t5_pc", 32'(pc), 0); chk("t5_ir", 32'(ir), 0);
    chk("t5_v", 32'(ir_valid), 0); chk("t5_ret", 32'(retired), 0); chk("t5_h", 32'(halted), 0);
    step(); rst_n = 1'b1;
    mem[5] = 9'h1FF;
    ir_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    wait_halt();
    chk("t6_ret", 32'(retired), 5); chk("t6_sat", 32'(retired2), 3); chk("t6_pc", 32'(pc), 5);
    start = 1'b1; step(); start = 1'b0;
    chk("t6_pc0", 32'(pc), 0); chk("t6_state", 32'(state), 1);
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 40) == 0);
      ir_ready = 1'($urandom);
      br_take = ($urandom_range(0, 3) == 0);
      br_target = 4'($urandom);
      if ($urandom_range(0, 15) == 0)
        mem[$urandom_range(0, 15)] = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
